// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer, synchronous flush and NOP bubbles.
// Optional stall/bubble counters are built when PIPE_STAGE_BUF_STATS_EN is defined.
module pipe_stage_buf #(
   parameter int DATA_W   = 32,
   parameter int NUM_DATA = 2,
   parameter int CTRL_W   = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CTRL_W-1:0]          in_ctrl,
   input  logic [NUM_DATA*DATA_W-1:0] in_data,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [NUM_DATA*DATA_W-1:0] out_data,
   output logic [1:0]                 occupancy,
   output logic [31:0]                stall_cnt,
   output logic [31:0]                bubble_cnt
);

   localparam int DW = NUM_DATA * DATA_W;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [1:0]        occupancy_q, occupancy_d;
   logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
   logic [DW-1:0]     out_data_q, out_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DW-1:0]     skid_data_q, skid_data_d;
   logic              accept_s, emit_s;
   logic              main_from_in_s, main_from_skid_s, skid_load_s;

   assign accept_s = in_valid & in_ready_q;
   assign emit_s   = out_valid_q & out_ready;

   always_comb begin
      state_d          = state_q;
      main_from_in_s   = 1'b0;
      main_from_skid_s = 1'b0;
      skid_load_s      = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_d        = ST_ONE;
                  main_from_in_s = 1'b1;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && emit_s) begin
                  main_from_in_s = 1'b1;
               end else if (accept_s) begin
                  state_d     = ST_TWO;
                  skid_load_s = 1'b1;
               end else if (emit_s) begin
                  state_d = ST_EMPTY;
               end else begin
                  state_d = ST_ONE;
               end
            end
            ST_TWO: begin
               if (emit_s) begin
                  state_d          = ST_ONE;
                  main_from_skid_s = 1'b1;
               end else begin
                  state_d = ST_TWO;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Data registers only load on a write; the ctrl word is zeroed whenever the stage goes empty.
   always_comb begin
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      out_data_d  = out_data_q;
      out_ctrl_d  = out_ctrl_q;
      if (skid_load_s) begin
         skid_ctrl_d = in_ctrl;
         skid_data_d = in_data;
      end else begin
         skid_ctrl_d = skid_ctrl_q;
         skid_data_d = skid_data_q;
      end
      if (main_from_in_s) begin
         out_ctrl_d = in_ctrl;
         out_data_d = in_data;
      end else if (main_from_skid_s) begin
         out_ctrl_d = skid_ctrl_q;
         out_data_d = skid_data_q;
      end else begin
         out_ctrl_d = out_ctrl_q;
         out_data_d = out_data_q;
      end
      if (state_d == ST_EMPTY) begin
         out_ctrl_d = {CTRL_W{1'b0}};
      end else begin
         out_ctrl_d = out_ctrl_d;
      end
      in_ready_d  = (state_d != ST_TWO);
      out_valid_d = (state_d != ST_EMPTY);
      occupancy_d = state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         occupancy_q <= 2'd0;
         out_ctrl_q  <= {CTRL_W{1'b0}};
         out_data_q  <= {DW{1'b0}};
         skid_ctrl_q <= {CTRL_W{1'b0}};
         skid_data_q <= {DW{1'b0}};
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         occupancy_q <= occupancy_d;
         out_ctrl_q  <= out_ctrl_d;
         out_data_q  <= out_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_ctrl  = out_ctrl_q;
   assign out_data  = out_data_q;
   assign occupancy = occupancy_q;

`ifdef PIPE_STAGE_BUF_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   // Saturating counters; only rst clears them, flush leaves them alone.
   always_comb begin
      if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (!out_valid_q && out_ready && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end else begin
         bubble_cnt_d = bubble_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q  <= 32'd0;
         bubble_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   assign stall_cnt  = 32'd0;
   assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_buf;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_ctrl;
   logic [63:0] in_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_ctrl;
   logic [63:0] out_data;
   logic [1:0]  occupancy;
   logic [31:0] stall_cnt;
   logic [31:0] bubble_cnt;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [63:0] c;
      logic [63:0] d;
   } ent_t;

   ent_t        mq[$];
   logic [63:0] m_last_data = 64'd0;
   logic [31:0] m_stall     = 32'd0;
   logic [31:0] m_bubble    = 32'd0;

   pipe_stage_buf #(.DATA_W(32), .NUM_DATA(2), .CTRL_W(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ctrl    (in_ctrl),
      .in_data    (in_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ctrl   (out_ctrl),
      .out_data   (out_data),
      .occupancy  (occupancy),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle from a negedge, advance the model at the posedge, then compare at the next negedge.
   task automatic cycle(input logic v, input logic [63:0] c, input logic [63:0] d,
                        input logic ordy, input logic fl, input logic rs);
      int   n;
      logic acc, em;
      ent_t e;
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      n   = mq.size();
      acc = v && (n < 2);
      em  = (n > 0) && ordy;
      @(posedge clk);
      if (rs) begin
         mq.delete();
         m_last_data = 64'd0;
         m_stall     = 32'd0;
         m_bubble    = 32'd0;
      end else begin
         if (n > 0 && !ordy && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (n == 0 && ordy && m_bubble != 32'hFFFF_FFFF) m_bubble++;
         if (fl) begin
            mq.delete();
         end else begin
            if (em) void'(mq.pop_front());
            if (acc) begin
               e.c = c;
               e.d = d;
               mq.push_back(e);
            end
         end
      end
      if (mq.size() > 0) m_last_data = mq[0].d;
      @(negedge clk);
      check_eq("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
      check_eq("in_ready", {63'd0, in_ready}, {63'd0, mq.size() < 2});
      check_eq("occupancy", {62'd0, occupancy}, 64'(mq.size()));
      check_eq("out_ctrl", out_ctrl, (mq.size() > 0) ? mq[0].c : 64'd0);
      check_eq("out_data", out_data, m_last_data);
`ifdef PIPE_STAGE_BUF_STATS_EN
      check_eq("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_stall});
      check_eq("bubble_cnt", {32'd0, bubble_cnt}, {32'd0, m_bubble});
`else
      check_eq("stall_cnt_off", {32'd0, stall_cnt}, 64'd0);
      check_eq("bubble_cnt_off", {32'd0, bubble_cnt}, 64'd0);
`endif
   endtask

   localparam logic [63:0] CA = 64'hAAAA_0001_0000_000A;
   localparam logic [63:0] CB = 64'hBBBB_0002_0000_000B;
   localparam logic [63:0] CC = 64'hCCCC_0003_0000_000C;
   localparam logic [63:0] CD = 64'hDDDD_0004_0000_000D;
   localparam logic [63:0] DA = 64'h0000_00A1_0000_00A0;

   initial begin
      logic [63:0] rc;
      in_valid = 1'b0; in_ctrl = 64'd0; in_data = 64'd0;
      out_ready = 1'b0; flush = 1'b0; rst = 1'b1;
      @(negedge clk);

      // reset and bubble
      cycle(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
      check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check_eq("rst_out_ctrl", out_ctrl, 64'd0);
      check_eq("rst_out_data", out_data, 64'd0);

      // streaming
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 64'(i + 1), {32'(32'h20 + i), 32'(32'h10 + i)}, 1'b1, 1'b0, 1'b0);
         check_eq("stream_ctrl", out_ctrl, 64'(i + 1));
         check_eq("stream_data", out_data, {32'(32'h20 + i), 32'(32'h10 + i)});
         check_eq("stream_occ", {62'd0, occupancy}, 64'd1);
         check_eq("stream_rdy", {63'd0, in_ready}, 64'd1);
      end
      cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);

      // back-pressure and stability
      cycle(1'b1, CA, DA, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, CB, 64'h0B, 1'b0, 1'b0, 1'b0);
      check_eq("bp_occ2", {62'd0, occupancy}, 64'd2);
      check_eq("bp_rdy0", {63'd0, in_ready}, 64'd0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, CC, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
         check_eq("stable_ctrl", out_ctrl, CA);
         check_eq("stable_data", out_data, DA);
      end
      cycle(1'b1, CC, 64'h0C, 1'b1, 1'b0, 1'b0);
      check_eq("bp_order_b", out_ctrl, CB);
      cycle(1'b1, CC, 64'h0C, 1'b1, 1'b0, 1'b0);
      check_eq("bp_order_c", out_ctrl, CC);
      cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      check_eq("bp_drain", {63'd0, out_valid}, 64'd0);

      // flush with a full buffer and D offered
      cycle(1'b1, CA, DA, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, CB, 64'h0B, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, CD, 64'h0D, 1'b0, 1'b1, 1'b0);
      check_eq("flush_valid", {63'd0, out_valid}, 64'd0);
      check_eq("flush_ctrl", out_ctrl, 64'd0);
      check_eq("flush_occ", {62'd0, occupancy}, 64'd0);
      cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      check_eq("flush_no_d", {63'd0, out_valid}, 64'd0);

`ifdef PIPE_STAGE_BUF_STATS_EN
      // counters: 5 stalls then 3 bubbles, then saturation
      cycle(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, CA, DA, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      check_eq("stats_stall5", {32'd0, stall_cnt}, 64'd5);
      check_eq("stats_bubble3", {32'd0, bubble_cnt}, 64'd3);
      cycle(1'b1, CA, DA, 1'b0, 1'b0, 1'b0);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      m_stall = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
      check_eq("stats_sat", {32'd0, stall_cnt}, 64'h0000_0000_FFFF_FFFF);
`endif

      // random traffic with occasional flush and reset
      for (int i = 0; i < 600; i++) begin
         rc = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
         cycle(1'($urandom_range(0, 1)), rc, {$urandom, $urandom},
               1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 63) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed inter-stage latches (control word plus one data word, plain load enable).
- Carries NUM_DATA data channels and a CTRL_W-bit control word between pipeline stages using a valid/ready handshake.
- Contains a 2-entry skid buffer, so back-pressure never forms a combinational ready path across stages.
- Supports synchronous flush for branch mispredict and traps, and presents a zeroed control word (NOP bubble) whenever its output is not valid.

Parameters:
- DATA_W, 32, width of each data channel.
- NUM_DATA, 2, number of data channels carried (e.g. ALU result and regfile mux output).
- CTRL_W, 64, width of the flattened control word; all-zero encodes a NOP.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  buffer accepts an entry this cycle; registered.
- in_ctrl  in  CTRL_W  upstream control word.
- in_data  in  NUM_DATA*DATA_W  upstream data; channel k occupies bits [k*DATA_W +: DATA_W].
- flush  in  1  discard all held entries.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head entry.
- out_ctrl  out  CTRL_W  head control word; forced to 0 when out_valid=0.
- out_data  out  NUM_DATA*DATA_W  head data.
- occupancy  out  2  number of held entries, 0..2.
- stall_cnt  out  32  stall-cycle counter (optional feature).
- bubble_cnt  out  32  bubble-cycle counter (optional feature).

Behaviour:
- Storage: main entry (drives outputs) and skid entry. States are EMPTY (occ 0), ONE (main valid), TWO (main and skid valid).
- Transfer rules:
  - accept = in_valid & in_ready.
  - emit = out_valid & out_ready.
  - in_ready = (state != TWO), registered from state.
- EMPTY:
  - accept: the entry is loaded into main, next state ONE.
  - out_valid=0.
- ONE:
  - accept and emit: the new entry replaces main, stay in ONE.
  - accept only: the new entry is written into skid, go to TWO.
  - emit only: go to EMPTY.
  - neither: hold.
- TWO:
  - emit: skid moves into main, go to ONE.
  - no emit: hold.
  - in_ready=0, so no accept is possible.
- Ordering: strict FIFO; entries leave in acceptance order with ctrl and all data channels kept together.
- Latency: an accepted entry appears on out_* the cycle after acceptance; there is no combinational in-to-out path.
- Flush has priority over all transfers:
  - next state is EMPTY and in_ready=1.
  - an entry offered on the flush cycle is dropped.
  - an emit on the flush cycle still counts as consumed downstream.
- rst:
  - state EMPTY, out_valid=0, in_ready=1, out_ctrl=0, out_data=0, occupancy=0, counters=0.
  - reset asserted mid-transfer discards everything.
- Bubble: out_ctrl equals 0 whenever out_valid=0, regardless of stored bits.
- Held data: out_data holds its last value when out_valid=0; data registers load only on write, with no per-cycle clearing.
- Handshake stability: when out_valid=1 and out_ready=0, out_ctrl and out_data remain stable until emit or flush.

Optional Feature:
- Macro PIPE_STAGE_BUF_STATS_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - bubble_cnt increments each cycle with out_valid=0 & out_ready=1.
  - both counters saturate at 32'hFFFF_FFFF and clear on rst only (flush does not clear them).
- Undefined: stall_cnt and bubble_cnt are tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset and bubble: assert rst for 2 cycles, then in_valid=0 -> out_valid=0, out_ctrl=0, in_ready=1, occupancy=0.
- Streaming: out_ready=1, in_data ch0=0x10+i, ch1=0x20+i, ctrl=i+1 for i=0..7 on consecutive cycles -> each entry appears one cycle later in order, in_ready stays 1, occupancy stays 1.
- Back-pressure: hold out_ready=0 and offer A, B, C:
  - A and B are accepted, occupancy=2, in_ready drops to 0 the cycle after B is accepted, and C is held upstream.
  - raise out_ready -> outputs A, B, C in order.
- Flush: with occupancy=2 and in_valid=1 carrying D, pulse flush -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and D never appears at the output.
- Stability: with out_valid=1 and out_ready=0 for 5 cycles -> out_ctrl and out_data remain bit-identical; toggling in_data has no effect.
- Stats (macro defined): 5 stall cycles then 3 idle cycles with out_ready=1 -> stall_cnt=5, bubble_cnt=3. Preload near saturation via force -> counter holds at 0xFFFFFFFF.
